// File: rtl/gpu_video_pkg.sv
// Shared 640x480@60 timing constants, RGB332 expansion and the sideband
// bundle that travels down the scanout pipeline next to the pixel data.
package gpu_video_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } scan_state_t;

  // Active-high flags; sync polarity is only applied at the output register.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic first;
  } sideband_t;

  // Each channel repeats its MSBs down to 8 bits so full scale maps to 0xFF.
  function automatic logic [23:0] rgb332_to_rgb888(input logic [7:0] pix);
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    r = pix[7:5];
    g = pix[4:2];
    b = pix[1:0];
    return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
  endfunction

endpackage

// File: rtl/fbuf_scanout_if.sv
// Read-only second port of the framebuffer BRAM as seen by the scanout stage.
interface fbuf_scanout_if #(
  parameter int FBUF_ADDR_WIDTH = 19,
  parameter int FBUF_DATA_WIDTH = 8
);
  logic                       fbuf_en_rd;
  logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr;
  logic [FBUF_DATA_WIDTH-1:0] fbuf_data;

  modport master (output fbuf_en_rd, output fbuf_addr, input fbuf_data);
  modport slave  (input fbuf_en_rd, input fbuf_addr, output fbuf_data);
endinterface

// File: rtl/video_timing_gen.sv
// Raster counters with an IDLE/RUN controller that only stops on a frame
// boundary, plus combinational active/sync/first-pixel decode.
module video_timing_gen
  import gpu_video_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic active,
  output logic hsync,
  output logic vsync,
  output logic first
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  scan_state_t   state, state_next;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          run, line_end, frame_end;

  assign run       = (state == ST_RUN);
  assign line_end  = (hcnt == HW'(H_TOTAL - 1));
  assign frame_end = line_end && (vcnt == VW'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (enable) state_next = ST_RUN;
      ST_RUN:  if (frame_end && !enable) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Counters sit at (0,0) while idle so a restart always begins a fresh frame.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (line_end) begin
      hcnt <= '0;
      vcnt <= frame_end ? '0 : vcnt + VW'(1);
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  assign active = run && (hcnt < HW'(H_ACTIVE)) && (vcnt < VW'(V_ACTIVE));
  assign hsync  = run && (hcnt >= HW'(H_ACTIVE + H_FP))
                      && (hcnt <  HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vsync  = run && (vcnt >= VW'(V_ACTIVE + V_FP))
                      && (vcnt <  VW'(V_ACTIVE + V_FP + V_SYNC));
  assign first  = run && (hcnt == '0) && (vcnt == '0);

endmodule

// File: rtl/fbuf_scanout.sv
// Framebuffer scanout: raster-order BRAM reads, sideband delay matched to the
// BRAM latency, and a registered RGB332->RGB888 output stage.
module fbuf_scanout
  import gpu_video_pkg::*;
#(
  parameter int FBUF_ADDR_WIDTH  = 19,
  parameter int FBUF_DATA_WIDTH  = 8,
  parameter int H_ACTIVE         = VGA_H_ACTIVE,
  parameter int H_FP             = VGA_H_FP,
  parameter int H_SYNC           = VGA_H_SYNC,
  parameter int H_BP             = VGA_H_BP,
  parameter int V_ACTIVE         = VGA_V_ACTIVE,
  parameter int V_FP             = VGA_V_FP,
  parameter int V_SYNC           = VGA_V_SYNC,
  parameter int V_BP             = VGA_V_BP,
  parameter int SYNC_ACTIVE_HIGH = 0,
  parameter int BRAM_LATENCY     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  fbuf_scanout_if.master      fbuf,
  output logic                vid_hsync,
  output logic                vid_vsync,
  output logic                vid_de,
  output logic [23:0]         vid_rgb,
  output logic                frame_start
);

  localparam logic SYNC_IDLE = (SYNC_ACTIVE_HIGH == 0);

  logic      active, hsync, vsync, first;
  sideband_t sb_pipe [BRAM_LATENCY+1];
  sideband_t sb_out;
  logic [FBUF_DATA_WIDTH-1:0] pixel;

  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk), .rst(rst), .enable(enable),
    .active(active), .hsync(hsync), .vsync(vsync), .first(first)
  );

  // Linear address: the raster walk is sequential, so a counter replaces y*W+x.
  always_ff @(posedge clk) begin
    if (rst) begin
      fbuf.fbuf_en_rd <= 1'b0;
      fbuf.fbuf_addr  <= '0;
    end else begin
      fbuf.fbuf_en_rd <= active;
      if (first)       fbuf.fbuf_addr <= '0;
      else if (active) fbuf.fbuf_addr <= fbuf.fbuf_addr + FBUF_ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= BRAM_LATENCY; i++) sb_pipe[i] <= '0;
    end else begin
      sb_pipe[0] <= {hsync, vsync, active, first};
      for (int i = 1; i <= BRAM_LATENCY; i++) sb_pipe[i] <= sb_pipe[i-1];
    end
  end

  assign sb_out = sb_pipe[BRAM_LATENCY];
  assign pixel  = fbuf.fbuf_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      vid_hsync   <= SYNC_IDLE;
      vid_vsync   <= SYNC_IDLE;
      vid_de      <= 1'b0;
      vid_rgb     <= '0;
      frame_start <= 1'b0;
    end else begin
      vid_hsync   <= sb_out.hsync ? ~SYNC_IDLE : SYNC_IDLE;
      vid_vsync   <= sb_out.vsync ? ~SYNC_IDLE : SYNC_IDLE;
      vid_de      <= sb_out.de;
      vid_rgb     <= sb_out.de ? rgb332_to_rgb888(pixel) : 24'h0;
      frame_start <= sb_out.first & sb_out.de;
    end
  end

endmodule

// File: tb/tb_fbuf_scanout.sv
// Scoreboard bench for fbuf_scanout: full-width lines with a short frame height.
module tb_fbuf_scanout;

  localparam int H_ACTIVE = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
  localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 8;
  localparam int NPIX = H_ACTIVE * V_ACTIVE;

  typedef struct {
    logic [23:0] rgb;
    logic        first;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic vid_hsync, vid_vsync, vid_de, frame_start;
  logic [23:0] vid_rgb;

  fbuf_scanout_if bus ();

  fbuf_scanout #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_ACTIVE_HIGH(0), .BRAM_LATENCY(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .fbuf(bus.master),
    .vid_hsync(vid_hsync), .vid_vsync(vid_vsync), .vid_de(vid_de),
    .vid_rgb(vid_rgb), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [NPIX];
  logic [7:0] bram_q1;
  exp_t       sb_q [$];
  int         exp_addr = 0;
  int         n_compared = 0;
  int         n_mismatched = 0;

  // Two-clock BRAM read port
  always @(posedge clk) begin
    if (bus.fbuf_en_rd)
      bram_q1 <= (int'(bus.fbuf_addr) < NPIX) ? mem[int'(bus.fbuf_addr)] : 8'h00;
    bus.fbuf_data <= bram_q1;
  end

  function automatic logic [23:0] expand(input logic [7:0] p);
    int r, g, b;
    r = int'(p[7:5]);
    g = int'(p[4:2]);
    b = int'(p[1:0]);
    return {8'((r << 5) | (r << 2) | (r >> 1)),
            8'((g << 5) | (g << 2) | (g >> 1)),
            8'(b * 85)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic en_v, input int cycles);
    rst    = rst_v;
    enable = en_v;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Reads push their expected pixel; the output side pops on every vid_de.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb_q.delete();
      exp_addr = 0;
    end else begin
      if (vid_de) begin
        if (sb_q.size() == 0) checkOutput("sb_underflow", sb_q.size(), 1);
        else begin
          e = sb_q.pop_front();
          checkOutput("rgb", vid_rgb, e.rgb);
          checkOutput("frame_start", frame_start, e.first);
        end
      end else begin
        checkOutput("rgb_blank", vid_rgb, 0);
        checkOutput("frame_start_blank", frame_start, 0);
      end
      if (bus.fbuf_en_rd) begin
        checkOutput("fbuf_addr", bus.fbuf_addr, exp_addr);
        e.rgb   = expand(mem[exp_addr]);
        e.first = (exp_addr == 0);
        sb_q.push_back(e);
        exp_addr = (exp_addr == NPIX - 1) ? 0 : exp_addr + 1;
      end
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0]  pix_tab [6];
    logic [23:0] colour_tab [6];
    int de_len, gap, hs_len, bp, t, period, vs_low, bad;
    bit seen, last_seen, wrap_checked;

    pix_tab    = '{8'hE0, 8'h1C, 8'h03, 8'h49, 8'h00, 8'h2D};
    colour_tab = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h494955, 24'h000000, 24'h246D55};
    for (int a = 0; a < NPIX; a++) mem[a] = 8'(a * 37 + 11);
    for (int a = 0; a < 6; a++) mem[a] = pix_tab[a];

    // Reset held with enable high
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 1);
      checkOutput("rst_en_rd", bus.fbuf_en_rd, 0);
      checkOutput("rst_de", vid_de, 0);
      checkOutput("rst_rgb", vid_rgb, 0);
      checkOutput("rst_hsync", vid_hsync, 1);
      checkOutput("rst_vsync", vid_vsync, 1);
    end
    applyStimulus(0, 0, 3);
    checkOutput("idle_en_rd", bus.fbuf_en_rd, 0);
    checkOutput("idle_addr", bus.fbuf_addr, 0);

    // First pixel: T0 is the edge that samples enable
    applyStimulus(0, 1, 1);
    applyStimulus(0, 1, 1);
    checkOutput("t1_en_rd", bus.fbuf_en_rd, 1);
    checkOutput("t1_addr", bus.fbuf_addr, 0);
    applyStimulus(0, 1, 2);
    checkOutput("t3_de", vid_de, 0);
    applyStimulus(0, 1, 1);
    checkOutput("t4_de", vid_de, 1);
    checkOutput("t4_frame_start", frame_start, 1);
    checkOutput("colour_0", vid_rgb, colour_tab[0]);
    for (int i = 1; i < 6; i++) begin
      applyStimulus(0, 1, 1);
      checkOutput("colour_n", vid_rgb, colour_tab[i]);
      checkOutput("no_frame_start", frame_start, 0);
    end

    // Line timing
    de_len = 6;
    applyStimulus(0, 1, 1);
    while (vid_de && de_len < 2000) begin de_len++; applyStimulus(0, 1, 1); end
    checkOutput("de_len", de_len, H_ACTIVE);
    checkOutput("addr_line0_last", bus.fbuf_addr, 639);
    checkOutput("en_rd_blank", bus.fbuf_en_rd, 0);
    gap = 0;
    while (vid_hsync && gap < 2000) begin gap++; applyStimulus(0, 1, 1); end
    checkOutput("hsync_delay", gap, H_FP);
    hs_len = 0;
    while (!vid_hsync && hs_len < 2000) begin hs_len++; applyStimulus(0, 1, 1); end
    checkOutput("hsync_len", hs_len, H_SYNC);
    bp = 0;
    seen = 0;
    while (!vid_de && bp < 2000) begin
      if (bus.fbuf_en_rd && !seen) begin
        checkOutput("addr_line1_first", bus.fbuf_addr, 640);
        seen = 1;
      end
      bp++;
      applyStimulus(0, 1, 1);
    end
    checkOutput("back_porch", bp, H_BP);
    checkOutput("line1_read_seen", seen, 1);

    // Frame wrap and frame period
    t = 0;
    while (!frame_start && t < 8000) begin t++; applyStimulus(0, 1, 1); end
    checkOutput("frame1_start_found", frame_start, 1);
    period = 0;
    vs_low = 0;
    last_seen = 0;
    wrap_checked = 0;
    do begin
      applyStimulus(0, 1, 1);
      period++;
      if (!vid_vsync) vs_low++;
      if (bus.fbuf_en_rd) begin
        if (last_seen && !wrap_checked) begin
          checkOutput("wrap_addr", bus.fbuf_addr, 0);
          wrap_checked = 1;
        end
        if (int'(bus.fbuf_addr) == NPIX - 1) last_seen = 1;
      end
    end while (!frame_start && period < 8000);
    checkOutput("frame_period", period, H_TOTAL * V_TOTAL);
    checkOutput("vsync_len", vs_low, V_SYNC * H_TOTAL);
    checkOutput("last_addr_seen", last_seen, 1);
    checkOutput("wrap_checked", wrap_checked, 1);

    // Enable dropped mid-frame: frame finishes, then idle
    applyStimulus(0, 1, 2 * H_TOTAL);
    last_seen = 0;
    for (int i = 0; i < H_TOTAL * V_TOTAL; i++) begin
      applyStimulus(0, 0, 1);
      if (bus.fbuf_en_rd && int'(bus.fbuf_addr) == NPIX - 1) last_seen = 1;
    end
    checkOutput("drop_frame_completed", last_seen, 1);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(0, 0, 1);
      if (bus.fbuf_en_rd || vid_de || !vid_hsync || !vid_vsync || frame_start) bad++;
    end
    checkOutput("idle_after_drop", bad, 0);
    checkOutput("sb_drained", sb_q.size(), 0);

    // Restart, then reset mid-frame at line 3 pixel 300
    applyStimulus(0, 1, 1);
    applyStimulus(0, 1, 3 * H_TOTAL + 300);
    checkOutput("pre_rst_de", vid_de, 1);
    applyStimulus(1, 1, 1);
    checkOutput("mid_rst_en_rd", bus.fbuf_en_rd, 0);
    checkOutput("mid_rst_addr", bus.fbuf_addr, 0);
    checkOutput("mid_rst_de", vid_de, 0);
    checkOutput("mid_rst_rgb", vid_rgb, 0);
    checkOutput("mid_rst_hsync", vid_hsync, 1);
    checkOutput("mid_rst_vsync", vid_vsync, 1);
    checkOutput("mid_rst_frame_start", frame_start, 0);
    applyStimulus(1, 1, 1);
    applyStimulus(0, 1, 1);
    applyStimulus(0, 1, 1);
    checkOutput("restart_en_rd", bus.fbuf_en_rd, 1);
    checkOutput("restart_addr", bus.fbuf_addr, 0);
    applyStimulus(0, 1, 3);
    checkOutput("restart_de", vid_de, 1);
    checkOutput("restart_frame_start", frame_start, 1);
    checkOutput("restart_rgb", vid_rgb, 24'hFF0000);
    applyStimulus(0, 1, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
